// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM channel, register block and dead-time stage.
//   PWM_DT_BITS : default width of dead-time registers and counters
//   dt_state_t  : gate-driver FSM state encoding
package pwm_pkg;

    localparam int unsigned PWM_DT_BITS = 16;

    typedef enum logic [2:0] {
        OFF,
        HI,
        LO,
        DT_TO_HI,
        DT_TO_LO,
        FAULT
    } dt_state_t;

endpackage

// File: rtl/pwm_dt_counter.sv
// Loadable down-counter that times one dead interval.
// Ports:
//   clk    in   system clock
//   n_rst  in   asynchronous active-low reset (count -> 0)
//   clr    in   synchronous clear to 0 (highest priority)
//   load   in   load 'value' into the counter
//   value  in   DT_BITS load value
//   dec    in   decrement by one (ignored at 0, so the count never wraps)
//   le1    out  count is 0 or 1: the interval ends on this edge
module pwm_dt_counter
    import pwm_pkg::*;
#(
    parameter int unsigned DT_BITS = PWM_DT_BITS
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               clr,
    input  logic               load,
    input  logic [DT_BITS-1:0] value,
    input  logic               dec,
    output logic               le1
);

    logic [DT_BITS-1:0] r_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= value;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign le1 = (r_cnt[DT_BITS-1:1] == '0);

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate driver with programmable dead time, placed after a PWM
// channel. Both gates are held low for dead_reg cycles around every
// transition of pwm_in; pulses shorter than the dead time are suppressed.
// Optional feature macro: PWM_DT_FAULT_EN (adds a latched fault shutdown).
// Ports:
//   clk           in   system clock, rising edge
//   n_rst         in   asynchronous active-low reset
//   pwm_in        in   PWM waveform (already polarity-adjusted)
//   enable        in   1 = drive gates, 0 = both gates low
//   dead_in       in   DT_BITS dead time in clk cycles
//   dead_wen      in   write strobe for dead_in
//   fault_in      in   (PWM_DT_FAULT_EN) force FAULT state
//   fault_clr     in   (PWM_DT_FAULT_EN) leave FAULT when fault_in is low
//   fault_latched out  (PWM_DT_FAULT_EN) 1 while in FAULT
//   out_hi        out  high-side gate (registered)
//   out_lo        out  low-side gate (registered)
//   dead_active   out  1 while a dead interval runs (registered)
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int unsigned DT_BITS = PWM_DT_BITS
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               pwm_in,
    input  logic               enable,
    input  logic [DT_BITS-1:0] dead_in,
    input  logic               dead_wen,
`ifdef PWM_DT_FAULT_EN
    input  logic               fault_in,
    input  logic               fault_clr,
    output logic               fault_latched,
`endif
    output logic               out_hi,
    output logic               out_lo,
    output logic               dead_active
);

    dt_state_t          r_state;
    dt_state_t          w_nxt;
    logic [DT_BITS-1:0] r_dead;
    logic               r_out_hi;
    logic               r_out_lo;
    logic               r_dead_active;
    logic               w_fault;
    logic               w_clr;
    logic               w_load;
    logic               w_dec;
    logic               w_le1;
    logic               w_dead_zero;

`ifdef PWM_DT_FAULT_EN
    logic               r_fault_latched;
    assign w_fault       = fault_in;
    assign fault_latched = r_fault_latched;
`else
    assign w_fault = 1'b0;
`endif

    assign w_dead_zero = (r_dead == '0);

    // The counter loads r_dead's pre-edge value, so a dead_wen on the same
    // edge only affects the following interval.
    pwm_dt_counter #(.DT_BITS(DT_BITS)) u_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (w_clr),
        .load  (w_load),
        .value (r_dead),
        .dec   (w_dec),
        .le1   (w_le1)
    );

    // Next state and counter strobes. Fault beats everything, then enable.
    always_comb begin
        w_nxt  = r_state;
        w_clr  = 1'b0;
        w_load = 1'b0;
        w_dec  = 1'b0;
        if (w_fault) begin
            w_nxt = FAULT;
            w_clr = 1'b1;
        end
`ifdef PWM_DT_FAULT_EN
        else if (r_state == FAULT) begin
            w_clr = 1'b1;
            if (fault_clr) w_nxt = OFF;
        end
`endif
        else if (!enable) begin
            w_nxt = OFF;
            w_clr = 1'b1;
        end else begin
            case (r_state)
                OFF: begin
                    // Safe start: always pass through a dead interval.
                    w_nxt  = pwm_in ? DT_TO_HI : DT_TO_LO;
                    w_load = 1'b1;
                end
                LO: begin
                    if (pwm_in) begin
                        if (w_dead_zero) begin
                            w_nxt = HI;
                        end else begin
                            w_nxt  = DT_TO_HI;
                            w_load = 1'b1;
                        end
                    end
                end
                HI: begin
                    if (!pwm_in) begin
                        if (w_dead_zero) begin
                            w_nxt = LO;
                        end else begin
                            w_nxt  = DT_TO_LO;
                            w_load = 1'b1;
                        end
                    end
                end
                DT_TO_HI: begin
                    if (!pwm_in)    w_nxt = LO;
                    else if (w_le1) w_nxt = HI;
                    else            w_dec = 1'b1;
                end
                DT_TO_LO: begin
                    if (pwm_in)     w_nxt = HI;
                    else if (w_le1) w_nxt = LO;
                    else            w_dec = 1'b1;
                end
                default: begin
                    w_nxt = OFF;
                    w_clr = 1'b1;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state into flops so the gates come
    // straight from registers and always match r_state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state         <= OFF;
            r_dead          <= '0;
            r_out_hi        <= 1'b0;
            r_out_lo        <= 1'b0;
            r_dead_active   <= 1'b0;
`ifdef PWM_DT_FAULT_EN
            r_fault_latched <= 1'b0;
`endif
        end else begin
            if (dead_wen) r_dead <= dead_in;
            r_state         <= w_nxt;
            r_out_hi        <= (w_nxt == HI);
            r_out_lo        <= (w_nxt == LO);
            r_dead_active   <= (w_nxt == DT_TO_HI) || (w_nxt == DT_TO_LO);
`ifdef PWM_DT_FAULT_EN
            r_fault_latched <= (w_nxt == FAULT);
`endif
        end
    end

    assign out_hi      = r_out_hi;
    assign out_lo      = r_out_lo;
    assign dead_active = r_dead_active;

endmodule
